// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, loadable instruction memory and the IF/ID register.
// One-edge fetch latency; stall holds PC and IF/ID, branch overrides stall, HALT_WORD freezes fetch.
module fetch_stage #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_WORD   = 16'h0000,
  parameter logic [15:0] HALT_WORD  = 16'hFFFF
) (
  input  logic                          inp_clk,
  input  logic                          inp_rst,
  input  logic                          inp_stall,
  input  logic                          inp_flush,
  input  logic                          inp_branch_taken,
  input  logic [15:0]                   inp_branch_target,
  input  logic                          inp_load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] inp_load_addr,
  input  logic [15:0]                   inp_load_data,
  output logic [15:0]                   out_instruction,
  output logic [15:0]                   out_pc,
  output logic                          out_valid,
  output logic                          out_halted
);
  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] opc_q, opc_d;
  logic        valid_q, valid_d;

  logic [15:0] imem [IMEM_DEPTH];
  logic [15:0] fetch_word;

  // Memory has no reset; a same-edge write/fetch collision returns the old word.
  always_ff @(posedge inp_clk) begin
    if (inp_load_en) imem[inp_load_addr] <= inp_load_data;
  end

  assign fetch_word = imem[pc_q[AW-1:0]];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    valid_d = valid_q;
    if (inp_branch_taken) begin
      pc_d    = inp_branch_target;
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (inp_stall) begin
      if (inp_flush) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    end else if (state_q == ST_HALTED) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (inp_flush) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      pc_d    = pc_q + 16'd1;
    end else begin
      instr_d = fetch_word;
      opc_d   = pc_q;
      valid_d = 1'b1;
      // HALT is presented once as valid while the PC parks on it.
      if (fetch_word == HALT_WORD) begin
        state_d = ST_HALTED;
      end else begin
        pc_d = pc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge inp_clk or posedge inp_rst) begin
    if (inp_rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      opc_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
    end
  end

  assign out_instruction = instr_q;
  assign out_pc          = opc_q;
  assign out_valid       = valid_q;
  assign out_halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed plan scenarios followed by randomized traffic against a reference model.
module tb_fetch_stage;
  logic        clk, rst, stall, flush, br, load_en;
  logic [15:0] tgt, ldata;
  logic [7:0]  laddr;
  logic [15:0] o_ins, o_pc;
  logic        o_val, o_halt;

  int n_total = 0;
  int n_pass  = 0;

  logic [15:0] m_mem [256];
  logic [15:0] m_pc, m_ins, m_opc;
  logic        m_val, m_halt;

  fetch_stage dut (
    .inp_clk(clk), .inp_rst(rst), .inp_stall(stall), .inp_flush(flush),
    .inp_branch_taken(br), .inp_branch_target(tgt),
    .inp_load_en(load_en), .inp_load_addr(laddr), .inp_load_data(ldata),
    .out_instruction(o_ins), .out_pc(o_pc), .out_valid(o_val), .out_halted(o_halt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] ins, input logic [15:0] pc,
                            input logic val, input logic hlt);
    check({tag, ".ins"}, {16'h0, o_ins}, {16'h0, ins});
    check({tag, ".pc"},  {16'h0, o_pc},  {16'h0, pc});
    check({tag, ".val"}, {31'h0, o_val}, {31'h0, val});
    check({tag, ".hlt"}, {31'h0, o_halt}, {31'h0, hlt});
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_ins = 16'h0000; m_opc = 16'h0000; m_val = 1'b0; m_halt = 1'b0;
  endtask

  // One clock edge of the architectural behaviour, read off the priority list.
  task automatic model_edge();
    logic [15:0] word;
    word = m_mem[m_pc[7:0]];
    if (rst) model_reset();
    else if (br) begin
      m_pc = tgt; m_ins = 16'h0000; m_val = 1'b0; m_halt = 1'b0;
    end else if (stall) begin
      if (flush) begin m_ins = 16'h0000; m_val = 1'b0; end
    end else if (m_halt) begin
      m_ins = 16'h0000; m_val = 1'b0;
    end else if (flush) begin
      m_ins = 16'h0000; m_val = 1'b0; m_pc = m_pc + 16'd1;
    end else begin
      m_ins = word; m_opc = m_pc; m_val = 1'b1;
      if (word == 16'hFFFF) m_halt = 1'b1;
      else m_pc = m_pc + 16'd1;
    end
    if (load_en) m_mem[laddr] = ldata;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    expect_out("model", m_ins, m_opc, m_val, m_halt);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; br = 1'b0; tgt = 16'h0;
    load_en = 1'b0; laddr = 8'h0; ldata = 16'h0;
    model_reset();
    #2;
    expect_out("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Fill memory while reset is held.
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      load_en = 1'b1;
      laddr   = 8'(i);
      ldata   = (r[31:28] == 4'h0) ? 16'hFFFF : r[15:0];
      case (i)
        0:       ldata = 16'h8510;
        1:       ldata = 16'hD76A;
        2:       ldata = 16'hFFFF;
        'h20:    ldata = 16'h1234;
        'h21:    ldata = 16'h1111;
        'h22:    ldata = 16'h2222;
        'hFF:    ldata = 16'hAAAA;
        default: ;
      endcase
      tick();
    end
    load_en = 1'b0;
    expect_out("rst_hold", 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    tick(); expect_out("seq0", 16'h8510, 16'h0000, 1'b1, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("stall", 16'h8510, 16'h0000, 1'b1, 1'b0);
    end
    stall = 1'b0;
    tick(); expect_out("seq1", 16'hD76A, 16'h0001, 1'b1, 1'b0);
    tick(); expect_out("halt", 16'hFFFF, 16'h0002, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(); expect_out("halted", 16'h0000, 16'h0002, 1'b0, 1'b1);
    end

    br = 1'b1; stall = 1'b1; tgt = 16'h0020;
    tick(); expect_out("br_bubble", 16'h0000, 16'h0002, 1'b0, 1'b0);
    br = 1'b0; stall = 1'b0;
    tick(); expect_out("br_target", 16'h1234, 16'h0020, 1'b1, 1'b0);
    flush = 1'b1;
    tick(); check("flush.val", {31'h0, o_val}, 32'h0); check("flush.ins", {16'h0, o_ins}, 32'h0);
    flush = 1'b0;
    tick(); expect_out("post_flush", 16'h2222, 16'h0022, 1'b1, 1'b0);

    br = 1'b1; tgt = 16'hFFFF;
    tick(); check("wrap.bubble", {31'h0, o_val}, 32'h0);
    br = 1'b0;
    tick(); expect_out("wrap_ffff", 16'hAAAA, 16'hFFFF, 1'b1, 1'b0);
    tick(); expect_out("wrap_0", 16'h8510, 16'h0000, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    rst = 1'b1;
    #1;
    model_reset();
    expect_out("async_rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      r       = $urandom;
      rst     = (r[7:0] == 8'h00);
      stall   = (r[10:8] == 3'd0);
      flush   = (r[14:11] == 4'd0);
      br      = (r[18:15] == 4'd0);
      load_en = (r[21:19] < 3'd2);
      tgt     = (r[22]) ? 16'(r[31:24]) : $urandom_range(0, 65535);
      laddr   = 8'($urandom_range(0, 255));
      ldata   = (r[23]) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
